mux_sel_arbiter: RTL

Two-requester round-robin arbiter that generates the select line for the 2:1 data mux stage directly downstream. `req1` and `req2` come from the two sources feeding mux inputs `in1` and `in2`. The block grants one source at a time and drives `sel` so the mux passes the granted source's data. A hold counter bounds how long one source can keep the mux while the other is waiting.

---
 rtl/mux_arb_pkg.sv | 21 ++
 rtl/hold_counter.sv | 42 ++++
 rtl/mux_sel_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux select arbiter.
//   - arb_state_e : FSM encoding (IDLE / GRANT1 / GRANT2)
//   - last_e      : which requester was granted most recently
//   - defaults    : HOLD_MAX and counter width
package mux_arb_pkg;

   localparam int unsigned HOLD_MAX_DEFAULT = 8;
   localparam int unsigned CNT_W_DEFAULT    = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT1 = 2'd1,
      GRANT2 = 2'd2
   } arb_state_e;

   typedef enum logic {
      LAST_REQ1 = 1'b0,
      LAST_REQ2 = 1'b1
   } last_e;

endpackage

// File: rtl/hold_counter.sv
// Saturating up-counter that measures how long the current grant has lasted.
// Ports:
//   clk   in  : clock, rising edge
//   rst_n in  : synchronous active-low reset, clears the count
//   clr   in  : synchronous clear (takes priority over en)
//   en    in  : count one more cycle
//   sat   out : count has reached HOLD_MAX-1 (and stays there)
module hold_counter
   import mux_arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT,
   parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic sat
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign sat = (cnt_q == CNT_W'(HOLD_MAX - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && !sat) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the select of a downstream 2:1 mux.
// A hold counter lets the owner keep the mux for at most HOLD_MAX cycles while
// the other requester is waiting.
// Ports:
//   clk   in  : clock, rising edge
//   rst_n in  : synchronous active-low reset
//   req1  in  : request from the source on mux in1
//   req2  in  : request from the source on mux in2
//   gnt1  out : in1 source owns the mux
//   gnt2  out : in2 source owns the mux
//   sel   out : mux select, 0 = in1, 1 = in2; held while idle
//   busy  out : either grant is high
module mux_sel_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = HOLD_MAX_DEFAULT,
   parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req1,
   input  logic req2,
   output logic gnt1,
   output logic gnt2,
   output logic sel,
   output logic busy
);

   arb_state_e state_q, state_d;
   last_e      last_q, last_d;
   logic       sel_q, sel_d;
   logic       entry;
   logic       cnt_clr, cnt_en, hold_sat;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req1 && req2) begin
               state_d = (last_q == LAST_REQ2) ? GRANT1 : GRANT2;
            end else if (req1) begin
               state_d = GRANT1;
            end else if (req2) begin
               state_d = GRANT2;
            end
         end
         GRANT1: begin
            if (!req1) begin
               state_d = req2 ? GRANT2 : IDLE;
            end else if (hold_sat && req2) begin
               state_d = GRANT2;
            end
         end
         GRANT2: begin
            if (!req2) begin
               state_d = req1 ? GRANT1 : IDLE;
            end else if (hold_sat && req1) begin
               state_d = GRANT1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Entering a grant (from IDLE or via handoff) restarts the hold window.
   assign entry   = (state_d != IDLE) && (state_d != state_q);
   assign cnt_clr = entry;
   assign cnt_en  = (state_q != IDLE) && (state_d == state_q);

   always_comb begin
      last_d = last_q;
      sel_d  = sel_q;
      if (entry) begin
         last_d = (state_d == GRANT2) ? LAST_REQ2 : LAST_REQ1;
         sel_d  = (state_d == GRANT2);
      end
   end

   hold_counter #(
      .HOLD_MAX (HOLD_MAX),
      .CNT_W    (CNT_W)
   ) u_hold_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .sat   (hold_sat)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= LAST_REQ2;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         sel_q   <= sel_d;
      end
   end

   assign gnt1 = (state_q == GRANT1);
   assign gnt2 = (state_q == GRANT2);
   assign sel  = sel_q;
   assign busy = gnt1 | gnt2;

endmodule
